// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared constants and types for the FIFO stream reader
package fifo_stream_reader_pkg;

    localparam int SKID_DEPTH = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } rd_state_t;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port plus output stream bundle
interface fifo_stream_reader_if #(
    parameter int WIDTH = 32
);
    logic             fifo_empty;
    logic             fifo_rd;
    logic             fifo_dvld;
    logic [WIDTH-1:0] fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_dvld, fifo_dout, m_ready,
        output fifo_rd, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_dvld, fifo_dout, m_ready,
        input  fifo_rd, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader_stream_buf3.sv
// rtl/fifo_stream_reader_stream_buf3.sv - 3-entry circular buffer with registered head
module stream_buf3
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [1:0]       r_occ;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = i_pop & (r_occ != 2'd0);
    assign w_push_ok = i_push & ((r_occ != 2'(SKID_DEPTH)) | w_pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_ptr];

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_push |-> ((r_occ != 2'(SKID_DEPTH)) || i_pop));

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - non-FWFT FIFO read master producing a framed valid/ready stream
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [LEN_W-1:0]     i_pkt_len,
    fifo_stream_reader_if.master bus,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_pkt_cnt
);

    logic             r_rd_ok;
    logic             r_inflight;
    logic [1:0]       w_occ;
    logic [WIDTH-1:0] w_head;
    logic             w_credit;
    logic             w_acc;

    rd_state_t        r_state,     w_state_nxt;
    logic [LEN_W-1:0] r_beat_cnt,  w_beat_cnt_nxt;
    logic [LEN_W-1:0] r_len_q,     w_len_q_nxt;
    logic [CNT_W-1:0] r_pkt_cnt,   w_pkt_cnt_nxt;
    logic             w_first;
    logic [LEN_W-1:0] w_len;
    logic [LEN_W-1:0] w_idx;
    logic             w_last;

    // Credit counts only registered state, so m_ready never reaches fifo_rd combinationally.
    assign w_credit    = (3'(w_occ) + 3'(r_inflight)) < 3'(SKID_DEPTH);
    assign bus.fifo_rd = r_rd_ok & i_en & ~bus.fifo_empty & w_credit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ok    <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_rd_ok    <= 1'b1;
            r_inflight <= bus.fifo_rd | (r_inflight & ~bus.fifo_dvld);
        end
    end

    stream_buf3 #(.WIDTH(WIDTH)) u_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (bus.fifo_dvld),
        .i_push_data (bus.fifo_dout),
        .i_pop       (w_acc),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    assign bus.m_valid = (w_occ != 2'd0);
    assign bus.m_data  = w_head;
    assign w_acc       = bus.m_valid & bus.m_ready;

    // An unbounded (len 0) stream has no packet to protect, so a new length applies on the next beat.
    assign w_first    = (r_state == IDLE) | (r_len_q == '0);
    assign w_len      = w_first ? i_pkt_len : r_len_q;
    assign w_idx      = w_first ? '0 : r_beat_cnt;
    assign w_last     = bus.m_valid & (w_len != '0) & (w_idx == w_len - LEN_W'(1));
    assign bus.m_last = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_len_q    <= w_len_q_nxt;
            r_pkt_cnt  <= w_pkt_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_len_q_nxt    = r_len_q;
        w_pkt_cnt_nxt  = r_pkt_cnt;
        if (w_acc) begin
            if (w_last) begin
                w_state_nxt    = IDLE;
                w_beat_cnt_nxt = '0;
                w_pkt_cnt_nxt  = r_pkt_cnt + CNT_W'(1);
            end else if (w_first) begin
                w_state_nxt = IN_PKT;
                w_len_q_nxt = i_pkt_len;
                if (i_pkt_len != '0) begin
                    w_beat_cnt_nxt = LEN_W'(1);
                end else if (r_beat_cnt != '1) begin
                    w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
                end
            end else begin
                w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
            end
        end
    end

    assign o_busy    = r_inflight | (w_occ != 2'd0);
    assign o_pkt_cnt = r_pkt_cnt;

    a_dvld_expected: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.fifo_dvld |-> r_inflight);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] pkt_len = 16'd0;
    logic        busy;
    logic [15:0] pkt_cnt;

    fifo_stream_reader_if #(.WIDTH(32)) bus ();

    fifo_stream_reader #(.WIDTH(32), .LEN_W(16), .CNT_W(16)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_pkt_len (pkt_len),
        .bus       (bus),
        .o_busy    (busy),
        .o_pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          rd_cnt = 0;
    int          produced = 0;

    // Standard-mode FIFO model: data and dvld appear the cycle after an accepted rd.
    logic [31:0] mem [0:4095];
    int          wi = 0;
    int          ri = 0;
    logic        dvld;
    logic [31:0] dout;

    assign bus.fifo_empty = (wi == ri);
    assign bus.fifo_dvld  = dvld;
    assign bus.fifo_dout  = dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvld <= 1'b0;
            dout <= '0;
            ri   <= wi;
        end else begin
            dvld <= bus.fifo_rd;
            if (bus.fifo_rd) begin
                dout <= mem[ri[11:0]];
                ri   <= ri + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic last, input bit track);
        mem[wi[11:0]] = d;
        wi = wi + 1;
        if (track) exp_q.push_back('{last: last, data: d});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy && wi == ri) && n < 5000) begin
            tick();
            n++;
        end
        chk(name, 64'(n < 5000), 64'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.fifo_rd) rd_cnt++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_valid && bus.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got data=%0h last=%0b expected none", bus.m_data, bus.m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.m_data !== e.data || bus.m_last !== e.last) begin
                        bad++;
                        $display("FAIL beat: got data=%0h last=%0b expected data=%0h last=%0b",
                                 bus.m_data, bus.m_last, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fifo_rd", 64'(bus.fifo_rd), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_data",  64'(bus.m_data),  64'd0);
        chk("rst_m_last",  64'(bus.m_last),  64'd0);
        chk("rst_busy",    64'(busy),        64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt),     64'd0);
        rst_n = 1'b1;
        tick();

        // 1: preload 8 words, pkt_len 4, check 2-cycle latency and framing
        pkt_len = 16'd4;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(32'(i), (i % 4) == 3, 1'b1);
        tick();
        en = 1'b1;
        @(negedge clk);
        chk("t1_rd_c0",    64'(bus.fifo_rd), 64'd1);
        chk("t1_valid_c0", 64'(bus.m_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_c1", 64'(bus.m_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_c2", 64'(bus.m_valid), 64'd1);
        chk("t1_data_c2",  64'(bus.m_data),  64'd0);
        wait_idle("t1_drain");
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd2);
        chk("t1_busy",    64'(busy),    64'd0);

        // 2: backpressure holds exactly three reads, then releases in order
        bus.m_ready = 1'b0;
        r0 = rd_cnt;
        for (int i = 0; i < 12; i++) push_word(32'(200 + i), (i % 4) == 3, 1'b1);
        repeat (12) tick();
        chk("t2_rd_pulses", 64'(rd_cnt - r0), 64'd3);
        chk("t2_valid",     64'(bus.m_valid), 64'd1);
        chk("t2_data",      64'(bus.m_data),  64'd200);
        chk("t2_busy",      64'(busy),        64'd1);
        repeat (4) tick();
        chk("t2_data_stable", 64'(bus.m_data), 64'd200);
        chk("t2_rd_stable",   64'(rd_cnt - r0), 64'd3);
        bus.m_ready = 1'b1;
        wait_idle("t2_drain");
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // 3: unbounded stream, then length 1
        pkt_len = 16'd0;
        for (int i = 0; i < 20; i++) push_word(32'(300 + i), 1'b0, 1'b1);
        wait_idle("t3_drain0");
        chk("t3_pkt_cnt0", 64'(pkt_cnt), 64'd5);
        pkt_len = 16'd1;
        for (int i = 0; i < 3; i++) push_word(32'(400 + i), 1'b1, 1'b1);
        wait_idle("t3_drain1");
        chk("t3_pkt_cnt1", 64'(pkt_cnt), 64'd8);

        // 4: en pulse of one cycle mid-packet, then resume
        pkt_len = 16'd5;
        push_word(32'd500, 1'b0, 1'b1);
        push_word(32'd501, 1'b0, 1'b1);
        wait_idle("t4_drain0");
        en = 1'b0;
        push_word(32'd502, 1'b0, 1'b1);
        push_word(32'd503, 1'b0, 1'b1);
        push_word(32'd504, 1'b1, 1'b1);
        r0 = rd_cnt;
        repeat (3) tick();
        chk("t4_no_rd",    64'(rd_cnt - r0), 64'd0);
        chk("t4_no_valid", 64'(bus.m_valid), 64'd0);
        en = 1'b1;
        @(negedge clk);
        chk("t4_rd_now", 64'(bus.fifo_rd), 64'd1);
        tick();
        en = 1'b0;
        repeat (6) tick();
        chk("t4_one_rd",   64'(rd_cnt - r0),   64'd1);
        chk("t4_left",     64'(exp_q.size()),  64'd2);
        chk("t4_busy",     64'(busy),          64'd0);
        chk("t4_pkt_mid",  64'(pkt_cnt),       64'd8);
        en = 1'b1;
        wait_idle("t4_drain1");
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd9);

        // 5: random backpressure and refill, pkt_len 3, 1000 words
        pkt_len = 16'd3;
        produced = 0;
        fork
            begin
                while (produced < 1000) begin
                    tick();
                    if ($urandom_range(0, 1) == 1) begin
                        push_word(32'(1000 + produced), (produced % 3) == 2, 1'b1);
                        produced++;
                    end
                end
            end
            begin
                int n = 0;
                while ((produced < 1000 || exp_q.size() != 0) && n < 20000) begin
                    tick();
                    bus.m_ready = ($urandom_range(0, 1) == 1);
                    n++;
                end
                bus.m_ready = 1'b1;
                chk("t5_budget", 64'(n < 20000), 64'd1);
            end
        join
        wait_idle("t5_drain");
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd342);

        // 6: reset mid-packet with two words buffered
        bus.m_ready = 1'b0;
        push_word(32'd600, 1'b0, 1'b0);
        push_word(32'd601, 1'b0, 1'b0);
        repeat (5) tick();
        chk("t6_valid_pre", 64'(bus.m_valid), 64'd1);
        chk("t6_data_pre",  64'(bus.m_data),  64'd600);
        rst_n = 1'b0;
        #1;
        chk("t6_fifo_rd", 64'(bus.fifo_rd), 64'd0);
        chk("t6_m_valid", 64'(bus.m_valid), 64'd0);
        chk("t6_m_data",  64'(bus.m_data),  64'd0);
        chk("t6_m_last",  64'(bus.m_last),  64'd0);
        chk("t6_busy",    64'(busy),        64'd0);
        chk("t6_pkt_cnt", 64'(pkt_cnt),     64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pkt_len = 16'd2;
        bus.m_ready = 1'b1;
        push_word(32'd700, 1'b0, 1'b1);
        push_word(32'd701, 1'b1, 1'b1);
        wait_idle("t6_drain");
        chk("t6_pkt_cnt_after", 64'(pkt_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
